instr_fetch_unit: RTL

- Fetch stage that sits directly upstream of the decode/execute datapath in the mips core.
- Generates fetch addresses and issues requests to instruction memory over a req/gnt/rvalid handshake, with in-order responses.
- Buffers returned words in a prefetch FIFO and presents {instr, pc, pc+4} to the consumer on a valid/ready interface.
- Branch/jump redirects flush the buffer and discard in-flight responses.

---
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect and decode-side handshake.
// The master modport is the fetch unit's view; the slave modport is the memory/consumer side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_pc4,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_pc4,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: issues in-order imem requests, buffers words in a prefetch FIFO, flushes on redirect.
// Optional macro IFU_BYPASS_EN forwards a response straight to the consumer when the FIFO is empty.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_unit_if.master  ifu
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;

    logic          issue;
    logic          handshake;
    logic          rsp;
    logic          take;
    logic          push;
    logic          pop;
    logic          fifo_valid;
    logic          bypass_hit;
    logic [31:0]   redirect_target;
    logic [31:0]   out_pc;

    // count + inflight never exceeds DEPTH, which is what makes FIFO overflow impossible.
    always_comb begin
        redirect_target = ifu.redirect_pc & ~32'd3;
        issue      = reset && !ifu.redirect_valid
                     && (({1'b0, count} + {1'b0, inflight}) < DEPTH_EXT);
        handshake  = issue && ifu.imem_gnt;
        rsp        = reset && ifu.imem_rvalid;
        take       = rsp && (drop == '0) && !ifu.redirect_valid;
        fifo_valid = reset && (count != '0);
        pop        = fifo_valid && ifu.instr_ready;
`ifdef IFU_BYPASS_EN
        bypass_hit = take && (count == '0);
        push       = take && !(bypass_hit && ifu.instr_ready);
`else
        bypass_hit = 1'b0;
        push       = take;
`endif
    end

    always_comb begin
        ifu.imem_req    = issue;
        ifu.imem_addr   = fetch_pc;
        ifu.instr_valid = 1'b0;
        ifu.instr       = '0;
        out_pc          = '0;
        ifu.instr_pc4   = '0;
        if (fifo_valid) begin
            ifu.instr_valid = 1'b1;
            ifu.instr       = fifo_instr[rd_ptr];
            out_pc          = fifo_pc[rd_ptr];
        end else if (bypass_hit) begin
            ifu.instr_valid = 1'b1;
            ifu.instr       = ifu.imem_rdata;
            out_pc          = resp_pc;
        end
        ifu.instr_pc = out_pc;
        if (ifu.instr_valid) begin
            ifu.instr_pc4 = out_pc + 32'd4;
        end
    end

    // A redirect turns every outstanding request into one to drop; drop is recomputed, never accumulated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(handshake) - CW'(rsp);
            if (ifu.redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop     <= inflight - CW'(rsp);
            end else begin
                if (handshake) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (take) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= ifu.imem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) push |-> (count != DEPTH_CNT));

endmodule
